// File: rtl/mux_bus_pkg.sv
// Shared types and default sizing for the multiplexed ALE/En/Rw bus responder.
package mux_bus_pkg;

    localparam int DEF_DATA_W = 5;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_OK = 2'd1,
        ACCESS  = 2'd2
    } state_e;

endpackage : mux_bus_pkg

// File: rtl/mux_bus_regfile.sv
// DEPTH x DATA_W register file: one synchronous write port, one combinational read port,
// contents cleared by the asynchronous reset.
module mux_bus_regfile
    import mux_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Next-state of the storage array: copy, then overlay the single write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d[waddr] = regs_q[waddr];
        end
    end

    // Storage flops with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rdata = regs_q[raddr];

endmodule : mux_bus_regfile

// File: rtl/mux_bus_responder.sv
// Responder end of the multiplexed ALE/En/Rw bus: address latch, access FSM and register file.
// Optional feature macro ADDR_AUTOINC_EN: post-increment the address after each valid access.
module mux_bus_responder
    import mux_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ale,
    input  logic              en,
    input  logic              rw,
    input  logic [DATA_W-1:0] ad_in,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic              ack,
    output logic              err
);

    state_e            state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] ad_out_q, ad_out_d;
    logic              ad_oe_q,  ad_oe_d;
    logic              ack_q,    ack_d;
    logic              err_q,    err_d;
    logic              we_s;
    logic [DATA_W-1:0] rd_data_s;
`ifdef ADDR_AUTOINC_EN
    // Remembers whether the current ACCESS was a real read/write (not an error).
    logic              acc_ok_q, acc_ok_d;
`endif

    mux_bus_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (addr_q),
        .wdata (ad_in),
        .raddr (addr_q),
        .rdata (rd_data_s)
    );

    // Next-state, address latch and output-register logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ad_out_d = ad_out_q;
        ad_oe_d  = ad_oe_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        we_s     = 1'b0;
`ifdef ADDR_AUTOINC_EN
        acc_ok_d = acc_ok_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    // Strobe without a latched address, or collision with ALE.
                    err_d   = 1'b1;
                    state_d = ACCESS;
`ifdef ADDR_AUTOINC_EN
                    acc_ok_d = 1'b0;
`endif
                end else if (ale) begin
                    addr_d  = ad_in[ADDR_W-1:0];
                    state_d = ADDR_OK;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR_OK: begin
                if (ale && en) begin
                    err_d   = 1'b1;
                    state_d = ACCESS;
`ifdef ADDR_AUTOINC_EN
                    acc_ok_d = 1'b0;
`endif
                end else if (ale) begin
                    addr_d  = ad_in[ADDR_W-1:0];
                    state_d = ADDR_OK;
                end else if (en) begin
                    ack_d   = 1'b1;
                    state_d = ACCESS;
`ifdef ADDR_AUTOINC_EN
                    acc_ok_d = 1'b1;
`endif
                    if (rw) begin
                        ad_out_d = rd_data_s;
                        ad_oe_d  = 1'b1;
                    end else begin
                        we_s = 1'b1;
                    end
                end else begin
                    state_d = ADDR_OK;
                end
            end
            ACCESS: begin
                if (en) begin
                    state_d = ACCESS;
                end else begin
                    ad_oe_d  = 1'b0;
                    ad_out_d = {DATA_W{1'b0}};
`ifdef ADDR_AUTOINC_EN
                    acc_ok_d = 1'b0;
                    if (acc_ok_q) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ADDR_OK;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                ad_oe_d  = 1'b0;
                ad_out_d = {DATA_W{1'b0}};
            end
        endcase
    end

    // State, address and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= {ADDR_W{1'b0}};
            ad_out_q <= {DATA_W{1'b0}};
            ad_oe_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef ADDR_AUTOINC_EN
            acc_ok_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
`ifdef ADDR_AUTOINC_EN
            acc_ok_q <= acc_ok_d;
`endif
        end
    end

    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign ack    = ack_q;
    assign err    = err_q;

endmodule : mux_bus_responder

// File: tb/tb_mux_bus_responder.sv
// Scoreboard bench for mux_bus_responder: stimulus pushes expected responses, a monitor checks them.
module tb_mux_bus_responder;

    logic       clk;
    logic       rst;
    logic       ale;
    logic       en;
    logic       rw;
    logic [4:0] ad_in;
    logic [4:0] ad_out;
    logic       ad_oe;
    logic       ack;
    logic       err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit       is_err;
        bit       is_read;
        logic [4:0] data;
    } exp_t;

    exp_t sb_q[$];

    mux_bus_responder dut (
        .clk    (clk),
        .rst    (rst),
        .ale    (ale),
        .en     (en),
        .rw     (rw),
        .ad_in  (ad_in),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .ack    (ack),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack/err pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && (ack || err)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b want none (t=%0t)", ack, err, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack", int'(ack), int'(!e.is_err));
                check("err", int'(err), int'(e.is_err));
                check("ad_oe", int'(ad_oe), int'(e.is_read));
                if (e.is_read) check("rdata", int'(ad_out), int'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ale(input logic [4:0] a);
        ale = 1'b1; en = 1'b0; ad_in = a;
        tick();
        ale = 1'b0; ad_in = 5'h00;
    endtask

    task automatic do_write(input logic [4:0] d);
        sb_q.push_back('{1'b0, 1'b0, 5'h00});
        en = 1'b1; rw = 1'b0; ad_in = d;
        tick();
        en = 1'b0; ad_in = 5'h00;
        tick();
    endtask

    task automatic do_read(input logic [4:0] exp_d);
        sb_q.push_back('{1'b0, 1'b1, exp_d});
        en = 1'b1; rw = 1'b1;
        tick();
        en = 1'b0; rw = 1'b0;
        tick();
    endtask

    task automatic do_err(input logic [4:0] a, input logic with_ale);
        sb_q.push_back('{1'b1, 1'b0, 5'h00});
        en = 1'b1; rw = 1'b0; ale = with_ale; ad_in = a;
        tick();
        en = 1'b0; ale = 1'b0; ad_in = 5'h00;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ale = 1'b0; en = 1'b0; rw = 1'b0; ad_in = 5'h00;
        #3;
        check("rst_ad_out", int'(ad_out), 0);
        check("rst_ad_oe", int'(ad_oe), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // En with no latched address.
        do_err(5'h1E, 1'b0);

        // Write 0x15 to address 3.
        do_ale(5'h03);
        do_write(5'h15);

        // Write 0x0A to address 6, then read with en held and rw/ale wiggled.
        do_ale(5'h06);
        do_write(5'h0A);
        do_ale(5'h06);
        sb_q.push_back('{1'b0, 1'b1, 5'h0A});
        en = 1'b1; rw = 1'b1;
        tick();
        rw = 1'b0; ale = 1'b1; ad_in = 5'h11;
        tick();
        check("hold_oe", int'(ad_oe), 1);
        check("hold_data", int'(ad_out), 32'h0A);
        ale = 1'b0; en = 1'b0; ad_in = 5'h00;
        tick();
        check("exit_oe", int'(ad_oe), 0);
        check("exit_data", int'(ad_out), 0);

        // Upper ad_in bits ignored: 0x1B selects address 3.
        do_ale(5'h1B);
        do_read(5'h15);

        // ALE+EN collision: error, no write; then a normal write to address 2.
        do_ale(5'h05);
        do_write(5'h0C);
        do_ale(5'h05);
        do_err(5'h13, 1'b1);
        do_ale(5'h02);
        do_write(5'h1F);
        do_ale(5'h02);
        do_read(5'h1F);
        do_ale(5'h05);
        do_read(5'h0C);

`ifdef ADDR_AUTOINC_EN
        // Consecutive strobes without ALE wrap from address 7 to 0.
        do_ale(5'h07);
        do_write(5'h01);
        do_write(5'h02);
        do_ale(5'h07);
        do_read(5'h01);
        do_ale(5'h00);
        do_read(5'h02);
`else
        // Address is consumed: a second strobe without ALE is an error.
        do_ale(5'h07);
        do_write(5'h01);
        do_err(5'h02, 1'b0);
        do_ale(5'h07);
        do_read(5'h01);
        do_ale(5'h00);
        do_read(5'h00);
`endif

        // Reset in the middle of a read.
        do_ale(5'h06);
        sb_q.push_back('{1'b0, 1'b1, 5'h0A});
        en = 1'b1; rw = 1'b1;
        tick();
        #5;
        rst = 1'b1;
        #1;
        check("mid_rst_oe", int'(ad_oe), 0);
        check("mid_rst_data", int'(ad_out), 0);
        check("mid_rst_ack", int'(ack), 0);
        check("mid_rst_err", int'(err), 0);
        en = 1'b0; rw = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            do_ale(5'(i));
            do_read(5'h00);
        end

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux_bus_responder
